// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR stimulus generator.
package fir_pkg;

    localparam int SAMPLE_W = 4;

    typedef enum logic [1:0] {
        MODE_IMPULSE = 2'b00,
        MODE_STEP    = 2'b01,
        MODE_RAMP    = 2'b10,
        MODE_SQUARE  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Sample value for one index; callers pre-compute the index-dependent flags.
    function automatic logic [SAMPLE_W-1:0] pattern_sample(
        input mode_e               m,
        input logic [SAMPLE_W-1:0] amp,
        input logic                first,
        input logic [SAMPLE_W-1:0] ramp,
        input logic                hi
    );
        logic [SAMPLE_W-1:0] s;
        case (m)
            MODE_IMPULSE: s = first ? amp : '0;
            MODE_STEP:    s = amp;
            MODE_RAMP:    s = ramp;
            MODE_SQUARE:  s = hi ? amp : '0;
            default:      s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fir_rate_div.sv
// Sample-rate divider: tick is high on the last cycle of each CLK_DIV-cycle period.
module fir_rate_div #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == TERM) ? '0 : cnt + 16'd1;
    end

    assign tick = en && (cnt == TERM);

endmodule

// File: rtl/fir_stim_gen.sv
// Burst pattern generator feeding a FIR filter at a divided sample rate.
module fir_stim_gen
    import fir_pkg::*;
#(
    parameter int CLK_DIV   = 100,
    parameter int BURST_LEN = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [3:0]          amplitude,
    input  logic [3:0]          half_period,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                done
);

    localparam logic [15:0] LAST_K = 16'(BURST_LEN - 1);

    state_e       state, state_next;
    mode_e        mode_q;
    logic [3:0]   amp_q, hp_q;
    logic [15:0]  k, k_next;
    logic [3:0]   phase_cnt, phase_next, hp_eff;
    logic         phase_hi, hi_next, wrap;
    logic         tick, accept, last, advance, finish;

    fir_rate_div #(.CLK_DIV(CLK_DIV)) u_rate_div (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_RUN),
        .clear (state != ST_RUN),
        .tick  (tick)
    );

    assign accept  = (state == ST_IDLE) && start && !stop;
    assign last    = (k == LAST_K);
    assign advance = (state == ST_RUN) && !stop && tick && !last;
    assign finish  = (state == ST_RUN) && !stop && tick && last;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN: begin
                if (stop)
                    state_next = ST_IDLE;
                else if (finish)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Square phase tracking; half_period of 0 behaves as 1.
    always_comb begin
        hp_eff     = (hp_q == 4'd0) ? 4'd1 : hp_q;
        wrap       = (phase_cnt == hp_eff - 4'd1);
        phase_next = wrap ? 4'd0 : phase_cnt + 4'd1;
        hi_next    = wrap ? ~phase_hi : phase_hi;
        k_next     = k + 16'd1;
    end

    // Outputs are registered one cycle ahead so sample_out and sample_valid line up.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_IMPULSE;
            amp_q        <= '0;
            hp_q         <= '0;
            k            <= '0;
            phase_cnt    <= '0;
            phase_hi     <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else if (accept) begin
            mode_q       <= mode_e'(mode);
            amp_q        <= amplitude;
            hp_q         <= half_period;
            k            <= '0;
            phase_cnt    <= '0;
            phase_hi     <= 1'b1;
            sample_out   <= pattern_sample(mode_e'(mode), amplitude, 1'b1, 4'd0, 1'b1);
            sample_valid <= 1'b1;
        end else if (advance) begin
            k            <= k_next;
            phase_cnt    <= phase_next;
            phase_hi     <= hi_next;
            sample_out   <= pattern_sample(mode_q, amp_q, 1'b0, k_next[3:0], hi_next);
            sample_valid <= 1'b1;
        end else begin
            sample_valid <= 1'b0;
            if ((state == ST_RUN) && (stop || finish))
                sample_out <= '0;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench: three generator configurations share stimulus, each test checks one of them.
module tb_fir_stim_gen;

    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic [1:0] mode;
    logic [3:0] amplitude, half_period;

    logic [3:0] so [3];
    logic       sv [3];
    logic       bz [3];
    logic       dn [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_s [64];

    always #5 clk = ~clk;

    fir_stim_gen #(.CLK_DIV(4), .BURST_LEN(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .amplitude(amplitude), .half_period(half_period),
        .sample_out(so[0]), .sample_valid(sv[0]), .busy(bz[0]), .done(dn[0]));

    fir_stim_gen #(.CLK_DIV(4), .BURST_LEN(20)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .amplitude(amplitude), .half_period(half_period),
        .sample_out(so[1]), .sample_valid(sv[1]), .busy(bz[1]), .done(dn[1]));

    fir_stim_gen #(.CLK_DIV(1), .BURST_LEN(8)) dut2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .amplitude(amplitude), .half_period(half_period),
        .sample_out(so[2]), .sample_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // {valid, busy, done, sample}
    function automatic logic [31:0] obs_of(input int sel);
        return {25'd0, sv[sel], bz[sel], dn[sel], so[sel]};
    endfunction

    // Expected outputs c cycles after start was accepted for a clean burst.
    function automatic logic [31:0] expect_at(input int c, input int div, input int blen);
        int kk;
        if (c >= 1 && c <= blen * div) begin
            kk = (c - 1) / div;
            return {25'd0, ((c - 1) % div) == 0, 1'b1, 1'b0, exp_s[kk]};
        end
        if (c == blen * div + 1)
            return {25'd0, 3'b001, 4'd0};
        return 32'd0;
    endfunction

    task automatic kick(input logic [1:0] m, input logic [3:0] a, input logic [3:0] hp);
        mode = m; amplitude = a; half_period = hp; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic burst(input string tag, input int sel, input int div, input int blen);
        for (int c = 1; c <= blen * div + 3; c++) begin
            chk($sformatf("%s c%0d", tag, c), obs_of(sel), expect_at(c, div, blen));
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 2'b00; amplitude = 4'd0; half_period = 4'd0;
        idle(3);
        chk("reset0", obs_of(0), 32'd0);
        chk("reset2", obs_of(2), 32'd0);
        reset = 1'b0;
        idle(2);

        // Impulse amplitude 9
        for (int i = 0; i < 64; i++) exp_s[i] = 4'd0;
        exp_s[0] = 4'd9;
        kick(2'b00, 4'd9, 4'd0);
        burst("impulse", 0, 4, 8);
        idle(90);

        // Square, half-period 2 then 0
        for (int i = 0; i < 8; i++) exp_s[i] = ((i / 2) % 2 == 0) ? 4'd15 : 4'd0;
        kick(2'b11, 4'd15, 4'd2);
        burst("sq_hp2", 0, 4, 8);
        idle(90);
        for (int i = 0; i < 8; i++) exp_s[i] = (i % 2 == 0) ? 4'd15 : 4'd0;
        kick(2'b11, 4'd15, 4'd0);
        burst("sq_hp0", 0, 4, 8);
        idle(90);

        // Ramp over 20 samples wraps past 15
        for (int i = 0; i < 20; i++) exp_s[i] = 4'(i % 16);
        kick(2'b10, 4'd3, 4'd0);
        burst("ramp20", 1, 4, 20);
        idle(90);

        // Ramp at one sample per clock
        for (int i = 0; i < 8; i++) exp_s[i] = 4'(i);
        kick(2'b10, 4'd3, 4'd0);
        burst("ramp_div1", 2, 1, 8);
        idle(90);

        // Step amplitude 6, stop the cycle after the third strobe
        for (int i = 0; i < 8; i++) exp_s[i] = 4'd6;
        kick(2'b01, 4'd6, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("stop_pre c%0d", c), obs_of(0), expect_at(c, 4, 8));
            if (c == 10) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        for (int c = 11; c <= 50; c++) begin
            chk($sformatf("stop_post c%0d", c), obs_of(0), 32'd0);
            step();
        end

        // start with stop in IDLE: nothing happens
        stop = 1'b1;
        kick(2'b01, 4'd6, 4'd0);
        stop = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk($sformatf("startstop c%0d", c), obs_of(0), 32'd0);
            step();
        end
        idle(90);

        // Step amplitude 5 with restart attempts and control changes mid-burst
        for (int i = 0; i < 8; i++) exp_s[i] = 4'd5;
        kick(2'b01, 4'd5, 4'd0);
        for (int c = 1; c <= 35; c++) begin
            chk($sformatf("ignore c%0d", c), obs_of(0), expect_at(c, 4, 8));
            start = (c == 3 || c == 7 || c == 33);
            if (c == 3) begin mode = 2'b10; amplitude = 4'd1; end
            step();
        end
        start = 1'b0;
        idle(90);

        // Reset at the fifth strobe aborts without done
        kick(2'b01, 4'd5, 4'd0);
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("rst_pre c%0d", c), obs_of(0), expect_at(c, 4, 8));
            if (c == 17) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        for (int c = 18; c <= 50; c++) begin
            chk($sformatf("rst_post c%0d", c), obs_of(0), 32'd0);
            step();
        end

        // Fresh burst after reset starts at k=0
        for (int i = 0; i < 64; i++) exp_s[i] = 4'd0;
        exp_s[0] = 4'd7;
        kick(2'b00, 4'd7, 4'd0);
        burst("fresh", 0, 4, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_stim_gen.md
FIR_STIM_GEN -- requirements
Module: fir_stim_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, meaning clocks per sample strobe (1 MHz at 100 MHz clk); legal range 1..65535.
REQ-002 SHALL have parameter BURST_LEN, default 16, meaning samples per burst; legal range 1..65535.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 stop  input  1  abort request; effective in RUN and IDLE.
REQ-007 mode  input  2  pattern select: 00 impulse, 01 step, 10 ramp, 11 square.
REQ-008 amplitude  input  4  unsigned pattern amplitude.
REQ-009 half_period  input  4  square half-period in samples.
REQ-010 sample_out  output  4  unsigned sample to the FIR filter's sample_in.
REQ-011 sample_valid  output  1  one-clk strobe marking a new sample_out value.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-clk pulse on normal burst completion.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 and stop=0 -> latch mode, amplitude, half_period; go to RUN; stop=1 wins over simultaneous start.
REQ-016 Latched controls SHALL remain constant for the whole burst; input changes during RUN are ignored.
REQ-017 First sample_valid strobe SHALL occur the cycle after start is accepted; subsequent strobes every CLK_DIV cycles.
REQ-018 sample_out SHALL update only on strobe cycles and hold between strobes.
REQ-019 Sample index k counts 0..BURST_LEN-1.
REQ-020 Impulse: k=0 -> amplitude, else 0.
REQ-021 Step: every sample = amplitude.
REQ-022 Ramp: sample = k mod 16 (wraps 15 -> 0); amplitude ignored.
REQ-023 Square: amplitude for half_period samples, then 0 for half_period samples, repeating, starting high at k=0; half_period=0 treated as 1.
REQ-024 After the last strobe, SHALL hold the last sample for CLK_DIV cycles, then enter DONE.
REQ-025 DONE: done=1 for exactly one cycle, sample_out=0, then IDLE unconditionally; start in DONE ignored.
REQ-026 stop=1 in RUN SHALL go to IDLE next cycle: sample_out=0, busy=0, no done, no further strobes.
REQ-027 start in RUN SHALL be ignored (no restart, no queueing).
REQ-028 CLK_DIV=1 SHALL give a strobe every cycle in RUN.
REQ-029 busy SHALL be 1 exactly in RUN cycles; sample_valid never high outside RUN.

Reset
REQ-030 reset SHALL take priority over all inputs and force IDLE, sample_out=0, sample_valid=0, busy=0, done=0, counters and latched controls to 0.
REQ-031 reset asserted mid-burst SHALL abort with no done pulse; next start begins a fresh burst at k=0.

Structure
REQ-032 Shared package fir_pkg SHALL hold SAMPLE_W=4, mode encodings, and the FSM state type.
REQ-033 Strobe generation SHALL be a sub-module fir_rate_div (counter, enable, clear, one-clk tick output, parameter CLK_DIV).
REQ-034 sample_out SHALL be driven directly from a register (no combinational output path).

Verification (CLK_DIV=4, BURST_LEN=8 unless stated; start accepted at cycle t)
REQ-035 Impulse, amplitude=9 -> valid at t+1, t+5, ..., t+29; samples 9,0,0,0,0,0,0,0; done at t+33; sample_out=0 after.
REQ-036 Square, amplitude=15, half_period=2 -> 15,15,0,0,15,15,0,0; repeat with half_period=0 -> 15,0,15,0,15,0,15,0.
REQ-037 Ramp, BURST_LEN=20 -> samples 0..15,0,1,2,3; busy high t+1..t+80; one done pulse.
REQ-038 Step amplitude=6, stop at 3rd strobe+1 -> next cycle busy=0, sample_out=0, no more valid, no done; start with stop same cycle in IDLE -> no burst.
REQ-039 Step amplitude=5, start re-pulsed and mode changed mid-burst -> ignored, all 8 samples 5; reset at 5th strobe -> all outputs 0 next cycle, no done, fresh start yields k=0.
REQ-040 CLK_DIV=1, ramp -> sample_valid high t+1..t+8 continuously, samples 0..7, done at t+9.
